// File: rtl/aes_pkg.sv
// Shared AES constants and types for the key schedule and the round datapath.
package aes_pkg;

  localparam int AES_NR = 10;

  typedef logic [31:0]  aes_word_t;
  typedef logic [127:0] aes_block_t;

  typedef enum logic {IDLE, EMIT} ksx_state_t;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

endpackage

// File: rtl/SBox.sv
// AES byte substitution: multiplicative inverse in GF(2^8) followed by the affine map.
module SBox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the inverse for a != 0 and yields 0 for a == 0, as AES requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = gf_mul(a, a);
    r  = sq;
    for (int i = 2; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  logic [7:0] inv;

  always_comb begin
    inv  = gf_inv(din);
    dout = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  end

endmodule

// File: rtl/aes_sub_word.sv
// Byte-wise S-box substitution of one 32-bit word (SubWord / one column of SubBytes).
module aes_sub_word
  import aes_pkg::*;
(
  input  aes_word_t din,
  output aes_word_t dout
);

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    SBox u_sbox (
      .din  (din[8*b +: 8]),
      .dout (dout[8*b +: 8])
    );
  end

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: emits round keys 0..10 over a valid/ready handshake.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         rk_ready,
  output logic         rk_valid,
  output logic [3:0]   rk_index,
  output logic [127:0] round_key,
  output logic         busy,
  output logic         done
);

  ksx_state_t state;
  aes_block_t key_p0;
  logic [3:0] idx_p0;

  aes_word_t  w0, w1, w2, w3;
  aes_word_t  rot_w, sub_w, t_w;
  aes_word_t  n0, n1, n2, n3;
  logic [7:0] rcon;

  assign {w0, w1, w2, w3} = key_p0;
  assign rot_w = {w3[23:0], w3[31:24]};

  aes_sub_word u_sub_word (
    .din  (rot_w),
    .dout (sub_w)
  );

  // Rcon for the key being produced is selected by the index of the key it derives from
  always_comb begin
    rcon = 8'h00;
    if (idx_p0 < 4'(NUM_ROUNDS)) rcon = RCON[idx_p0 + 4'd1];
  end

  assign t_w = sub_w ^ {rcon, 24'h000000};
  assign n0  = w0 ^ t_w;
  assign n1  = w1 ^ n0;
  assign n2  = w2 ^ n1;
  assign n3  = w3 ^ n2;

  // ---- stage p0: key register and control, updated on the handshake edge ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      key_p0   <= '0;
      idx_p0   <= '0;
      rk_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            key_p0   <= key_in;
            idx_p0   <= '0;
            rk_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= EMIT;
          end
        end
        EMIT: begin
          if (rk_ready) begin
            if (idx_p0 == 4'(NUM_ROUNDS)) begin
              rk_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= IDLE;
            end else begin
              key_p0 <= {n0, n1, n2, n3};
              idx_p0 <= idx_p0 + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign round_key = key_p0;
  assign rk_index  = idx_p0;

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: FIPS-197 vectors, random keys, backpressure, reset and restart cases.
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         rk_ready;
  logic         rk_valid;
  logic [3:0]   rk_index;
  logic [127:0] round_key;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  aes_key_expand #(.NUM_ROUNDS(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_in    (key_in),
    .rk_ready  (rk_ready),
    .rk_valid  (rk_valid),
    .rk_index  (rk_index),
    .round_key (round_key),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  logic [7:0] sb [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  logic [127:0] exp_k [0:10];
  logic [127:0] got_k [0:10];
  logic [31:0]  w [0:43];

  // Reference schedule as the word-recurrence w[i] = w[i-4] ^ f(w[i-1])
  task automatic model(input logic [127:0] k);
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    {w[0], w[1], w[2], w[3]} = k;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) exp_k[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [127:0] k);
    start  = 1'b1;
    key_in = k;
    tick();
    start  = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    chk("lat_valid", 128'(rk_valid), 128'd1);
    chk("lat_index", 128'(rk_index), 128'd0);
    chk("lat_key", round_key, k);
    chk("lat_busy", 128'(busy), 128'd1);
  endtask

  // Consume one full sequence; poke_at >= 0 pulses start with a different key at that index
  task automatic stream(input logic [127:0] k, input int ready_pct, input int poke_at,
                        input string tag);
    int got, cyc, vcyc;
    logic stalled;
    logic [127:0] hold_k;
    logic [3:0] hold_i;
    model(k);
    got = 0; cyc = 0; vcyc = 0; stalled = 1'b0;
    hold_k = '0; hold_i = '0;
    while (got < 11 && cyc < 400) begin
      if (stalled) begin
        chk({tag, "_stall_key"}, round_key, hold_k);
        chk({tag, "_stall_idx"}, 128'(rk_index), 128'(hold_i));
        chk({tag, "_stall_vld"}, 128'(rk_valid), 128'd1);
      end
      if (rk_valid) vcyc++;
      start  = (poke_at >= 0 && got == poke_at && rk_valid);
      if (start) key_in = ~k;
      rk_ready = ($urandom_range(99) < ready_pct);
      if (rk_valid && rk_ready) begin
        chk({tag, "_idx"}, 128'(rk_index), 128'(got));
        chk({tag, "_key"}, round_key, exp_k[got]);
        chk({tag, "_nodone"}, 128'(done), 128'd0);
        got_k[got] = round_key;
        got++;
        stalled = 1'b0;
      end else if (rk_valid) begin
        stalled = 1'b1;
        hold_k  = round_key;
        hold_i  = rk_index;
      end else begin
        stalled = 1'b0;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_count"}, 128'(got), 128'd11);
    if (ready_pct >= 100) chk({tag, "_vcycles"}, 128'(vcyc), 128'd11);
    chk({tag, "_done"}, 128'(done), 128'd1);
    chk({tag, "_busy_end"}, 128'(busy), 128'd0);
    chk({tag, "_vld_end"}, 128'(rk_valid), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] ka1, kr;
    int n;
    ka1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rst = 1'b1; start = 1'b0; key_in = '0; rk_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", 128'(rk_valid), 128'd0);
    chk("rst_index", 128'(rk_index), 128'd0);
    chk("rst_key", round_key, 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);

    // start together with reset: reset wins
    start = 1'b1; key_in = ka1;
    tick();
    start = 1'b0; rst = 1'b0;
    chk("rst_start_vld", 128'(rk_valid), 128'd0);
    tick();
    chk("rst_start_idle", 128'(busy), 128'd0);

    // FIPS-197 A.1 at full rate
    do_start(ka1);
    stream(ka1, 100, -1, "a1");
    chk("a1_k1", got_k[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("a1_k10", got_k[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    tick();
    chk("a1_done_once", 128'(done), 128'd0);

    // all-zero key
    do_start(128'd0);
    stream(128'd0, 100, -1, "zero");
    chk("zero_k1", got_k[1], 128'h62636363626363636263636362636363);
    chk("zero_k10", got_k[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    tick();

    // backpressure with A.1
    do_start(ka1);
    stream(ka1, 50, -1, "bp");
    tick();

    // start ignored while busy
    do_start(ka1);
    stream(ka1, 100, 4, "poke");
    tick();

    // reset mid-expansion
    rk_ready = 1'b1;
    do_start(ka1);
    n = 0;
    while (rk_index != 4'd6 && n < 50) begin
      tick();
      n++;
    end
    chk("reach_idx6", 128'(rk_index), 128'd6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_vld", 128'(rk_valid), 128'd0);
    chk("mid_rst_busy", 128'(busy), 128'd0);
    chk("mid_rst_key", round_key, 128'd0);
    chk("mid_rst_idx", 128'(rk_index), 128'd0);
    kr = {$urandom, $urandom, $urandom, $urandom};
    do_start(kr);
    stream(kr, 100, -1, "after_rst");

    // back-to-back: start in the done cycle with the zero key
    start = 1'b1; key_in = 128'd0;
    tick();
    start = 1'b0;
    chk("b2b_vld", 128'(rk_valid), 128'd1);
    chk("b2b_idx", 128'(rk_index), 128'd0);
    stream(128'd0, 100, -1, "b2b");
    tick();

    // random keys with random backpressure
    for (int r = 0; r < 6; r++) begin
      kr = {$urandom, $urandom, $urandom, $urandom};
      do_start(kr);
      stream(kr, 40 + 10 * r, -1, "rand");
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_key_expand.md
# aes_key_expand

Iterative AES-128 key-schedule engine that turns a 128-bit cipher key into the 11 round keys (round 0 to round 10), one key per accepted handshake. It sits upstream of the AddRoundKey/round datapath and reuses the existing `SBox` byte-substitution block for the SubWord step. Keys are generated on the fly, with no key RAM, so the round datapath consumes each round key as it is produced.

## Interface
Parameters:
- `NUM_ROUNDS`, default 10: last round-key index. Fixed at 10 for AES-128; other values are unsupported.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: begin an expansion. Sampled only in IDLE.
- `key_in` in 128: cipher key, captured on an accepted `start`. `key_in[127:96]` is word w0 and byte 0 is `key_in[127:120]`.
- `rk_ready` in 1: downstream accepts the current round key.
- `rk_valid` out 1: `round_key`/`rk_index` are valid.
- `rk_index` out 4: round number 0..10 of `round_key`.
- `round_key` out 128: current round key, same word/byte ordering as `key_in`.
- `busy` out 1: high while not in IDLE.
- `done` out 1: one-cycle pulse after round key 10 is accepted.

## Operation
- FSM states:
  - IDLE: on `start`=1, load `key_in` into the key register, clear the index and Rcon, go to EMIT.
  - EMIT: `rk_valid`=1. On `rk_valid & rk_ready`:
    - if `rk_index`==10, go to IDLE and pulse `done`;
    - otherwise load the next key, increment `rk_index`, advance Rcon, stay in EMIT.
- Next-key function, from the current key words w0..w3:
  - t = SubWord(RotWord(w3)) ^ {Rcon, 24'h0}.
  - RotWord maps bytes [a0,a1,a2,a3] to [a1,a2,a3,a0].
  - SubWord applies `SBox` to each byte.
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
- Rcon for rounds 1..10 is 01,02,04,08,10,20,40,80,1B,36. Index with `rk_index`, not a shifted register.
- `start` in EMIT is ignored. `key_in` changes after capture have no effect.
- All XOR arithmetic is 8/32-bit with no carries. `rk_index` never exceeds 10.

## Timing
- Reset values: state IDLE, `rk_valid`=0, `rk_index`=0, `round_key`=0, `busy`=0, `done`=0.
- Latency: `start` accepted at edge N gives `rk_valid`=1, `rk_index`=0, `round_key`=`key_in` from edge N+1.
- Throughput: one round key per cycle when `rk_ready` is held high. Eleven cycles of `rk_valid` run back-to-back.
- Stall: while `rk_valid` & !`rk_ready`, `round_key` and `rk_index` hold stable and `rk_valid` stays high. `rk_valid` never drops without a handshake, except on reset.
- The next key is computed combinationally from the registered key (four `SBox` in parallel plus XORs) and registered on the handshake edge. There is no extra pipeline stage.
- `done` is high in the cycle after the final handshake; `busy`=0 in that same cycle.
- `start` may be asserted in that same cycle (state is IDLE), giving back-to-back expansions with one idle cycle between them.
- `start` and `rst` high together: reset wins.
- `rst` mid-expansion: return to IDLE next edge with all outputs at reset values. A partial key sequence is abandoned.

## Structure
- Shared package `aes_pkg`:
  - `AES_NR` = 10;
  - `RCON` constant array [1:10] of 8-bit;
  - typedef `aes_word_t` (32-bit);
  - typedef `aes_block_t` (128-bit);
  - FSM state enum `ksx_state_t` {IDLE, EMIT}.
- Sub-module: one natural one, `aes_sub_word`. It wraps four `SBox` instances to map a 32-bit word byte-wise and is reused later by the cipher's SubBytes stage.
- Implementation target: about 150–250 lines total.

## Test plan
- FIPS-197 A.1: `key_in`=2b7e151628aed2a6abf7158809cf4f3c with `rk_ready`=1.
  - Index 0 equals the key.
  - Index 1 = a0fafe1788542cb123a339392a6c7605.
  - Index 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - `done` pulses once, exactly 11 valid cycles.
- All-zero key:
  - Index 1 = 62636363626363636263636362636363.
  - Index 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Backpressure: A.1 key with `rk_ready` randomly low ~50%. The same 11 keys arrive in order, and data is stable during every stall.
- Start ignored while busy: pulse `start` with a different key at index 4. The sequence continues unchanged and the new key is not loaded.
- Reset mid-operation: assert `rst` at index 6. The next cycle shows `rk_valid`=0, `busy`=0, `round_key`=0. A subsequent `start` yields correct index 0..10.
- Back-to-back: assert `start` in the `done` cycle with the zero key. Index 0 appears on the following cycle and the full zero-key sequence is correct.
